// File: rtl/strip_result_drain_pkg.sv
// strip_result_drain_pkg: shared widths, FSM encoding, beat layout and requantisation for the strip result drain.
package strip_result_drain_pkg;
    localparam int RES_W  = 23;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 13;
    localparam int ROW_W  = 10;
    localparam int COL_W  = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_FLUSH  = 3'd3;
    localparam logic [2:0] ST_NEXT   = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    typedef struct packed {
        logic signed [PIX_W-1:0] pixel;
        logic [ROW_W-1:0]        row;
        logic [COL_W-1:0]        col;
    } beat_t;

    // Round-half-up shift at one extra bit of headroom, optional ReLU, then saturate to the pixel range.
    function automatic logic signed [PIX_W-1:0] requant(input logic signed [RES_W-1:0] sum,
                                                        input logic [3:0] shift, input logic relu);
        logic [RES_W:0] rnd;
        logic signed [RES_W:0] t;
        logic signed [RES_W:0] v;
        rnd = (shift == 4'd0) ? '0 : ((RES_W+1)'(1) << (shift - 4'd1));
        t = {sum[RES_W-1], sum} + $signed(rnd);
        v = t >>> shift;
        if (relu && v[RES_W]) v = '0;
        requant = (&v[RES_W:PIX_W-1] || ~|v[RES_W:PIX_W-1]) ? v[PIX_W-1:0]
                : (v[RES_W] ? {1'b1, {(PIX_W-1){1'b0}}} : {1'b0, {(PIX_W-1){1'b1}}});
    endfunction
endpackage

// File: rtl/strip_result_drain_if.sv
// strip_result_drain_if: valid/ready pixel stream leaving the drain.
interface strip_result_drain_if;
    import strip_result_drain_pkg::*;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [PIX_W-1:0] out_pixel;
    logic [ROW_W-1:0]        out_row;
    logic [COL_W-1:0]        out_col;

    modport master (output out_valid, out_pixel, out_row, out_col, input out_ready);
    modport slave  (input out_valid, out_pixel, out_row, out_col, output out_ready);
endinterface

// File: rtl/strip_result_drain_fifo.sv
// drain_fifo: synchronous show-ahead FIFO with occupancy count and synchronous reset.
module drain_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
            end
            if (i_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
endmodule

// File: rtl/strip_result_drain.sv
// strip_result_drain: waits on each strip's done, reads its result BRAM under credit flow control,
// requantises and streams pixels in raster order, then pulses frame_done.
module strip_result_drain
    import strip_result_drain_pkg::*;
#(
    parameter int NUM_STRIPS = 3,
    parameter int OUT_COLS   = 222,
    parameter int OUT_ROWS   = 28,
    parameter int RD_LATENCY = 2,
    parameter int SHIFT      = 6,
    parameter int RELU       = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_start,
    input  logic [NUM_STRIPS-1:0]       i_strip_done,
    input  logic [NUM_STRIPS*RES_W-1:0] i_strip_data,
    output logic [ADDR_W-1:0]           o_strip_addr,
    output logic                        o_busy,
    output logic                        o_frame_done,
    strip_result_drain_if.master        out_if
);
    localparam int DEPTH = RD_LATENCY + 2;
    localparam int NPIX  = OUT_COLS * OUT_ROWS;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
    localparam int NP    = 1 << SW;

    logic [2:0]              r_state;
    logic [SW-1:0]           r_strip;
    logic [ADDR_W-1:0]       r_addr;
    logic [ROW_W-1:0]        r_row;
    logic [COL_W-1:0]        r_col;
    logic [RD_LATENCY-1:0]   r_vld;
    logic [ROW_W-1:0]        r_tag_row [RD_LATENCY];
    logic [COL_W-1:0]        r_tag_col [RD_LATENCY];
    logic                    r_busy, r_done;
    logic [CW-1:0]           w_count, w_inflight, w_credits;
    logic [NP-1:0]           w_done;
    logic                    w_issue, w_pop, w_empty;
    logic signed [RES_W-1:0] w_sum;
    beat_t                   w_beat, w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight + CW'(r_vld[i]);
    end

    // Credits cover reads still in the BRAM pipe as well as beats parked in the FIFO.
    assign w_credits = CW'(DEPTH) - w_inflight - w_count;
    assign w_done    = NP'(i_strip_done);
    assign w_issue   = (r_state == ST_DRAIN) && (w_credits != '0);
    assign w_pop     = out_if.out_valid && out_if.out_ready;
    assign w_sum     = i_strip_data[int'(r_strip) * RES_W +: RES_W];
    assign w_beat    = {requant(w_sum, 4'(SHIFT), 1'(RELU)), r_tag_row[RD_LATENCY-1], r_tag_col[RD_LATENCY-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_strip <= '0;
            r_addr  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_vld   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_vld[0] <= w_issue;
            for (int i = 1; i < RD_LATENCY; i++) r_vld[i] <= r_vld[i-1];
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_state <= ST_WAIT;
                    r_busy  <= 1'b1;
                    r_strip <= '0;
                    r_row   <= '0;
                end
                ST_WAIT: if (w_done[r_strip]) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_issue) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_col  <= (r_col == COL_W'(OUT_COLS - 1)) ? '0 : r_col + COL_W'(1);
                    r_row  <= (r_col == COL_W'(OUT_COLS - 1)) ? r_row + ROW_W'(1) : r_row;
                    if (r_addr == ADDR_W'(NPIX - 1)) r_state <= ST_FLUSH;
                end
                ST_FLUSH: if (r_vld == '0) r_state <= ST_NEXT;
                ST_NEXT: begin
                    r_addr  <= '0;
                    r_col   <= '0;
                    r_state <= (r_strip == SW'(NUM_STRIPS - 1)) ? ST_FINISH : ST_WAIT;
                    r_strip <= (r_strip == SW'(NUM_STRIPS - 1)) ? r_strip : r_strip + SW'(1);
                end
                ST_FINISH: if (w_count == '0) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Row/column tags ride alongside the read-valid pipe so each landing word knows its position.
    always_ff @(posedge clk) begin
        r_tag_row[0] <= r_row;
        r_tag_col[0] <= r_col;
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_tag_row[i] <= r_tag_row[i-1];
            r_tag_col[i] <= r_tag_col[i-1];
        end
    end

    drain_fifo #(.W($bits(beat_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_vld[RD_LATENCY-1]),
        .i_data  (w_beat),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign out_if.out_valid = !w_empty;
    assign out_if.out_pixel = w_head.pixel;
    assign out_if.out_row   = w_head.row;
    assign out_if.out_col   = w_head.col;
    assign o_strip_addr     = r_addr;
    assign o_busy           = r_busy;
    assign o_frame_done     = r_done;
endmodule

// File: tb/tb_strip_result_drain.sv
// tb_strip_result_drain: randomised drain of a 3-strip frame and a 1-strip requant frame against a queue-free beat model.
module tb_strip_result_drain;
    import strip_result_drain_pkg::*;

    localparam int NS = 3, C = 222, R = 28, N = C * R, TOTAL = NS * N, DEPTH = 4;

    logic clk = 0, reset = 1, start = 0, start_b = 0;
    logic [NS-1:0] done = '0;
    logic done_b = 0;
    logic [NS*23-1:0] data;
    logic [22:0] data_b;
    logic [12:0] addr, addr_b, a1, a2, b1, b2;
    logic busy, fdone, busy_b, fdone_b;
    logic signed [22:0] lut [NS][256];
    int tbl_b [5] = '{-1000, -31, 31, 8191, -8192};
    int exp_b [5] = '{-16, 0, 0, 127, -128};
    int checks = 0, errors = 0;
    int exp_idx = 0, done_cnt = 0, addr_strip = 0, fb_cnt = 0;
    logic [12:0] prev_addr = '0;
    bit armed = 0, prev_stall = 0, rnd_ready = 0;
    int qpix[$], qcol[$], qrow[$];

    strip_result_drain_if ifa();
    strip_result_drain_if ifb();

    always #5 clk = ~clk;

    strip_result_drain #(.NUM_STRIPS(NS)) dut_a (
        .clk(clk), .reset(reset), .i_start(start), .i_strip_done(done), .i_strip_data(data),
        .o_strip_addr(addr), .o_busy(busy), .o_frame_done(fdone), .out_if(ifa.master));

    strip_result_drain #(.NUM_STRIPS(1), .OUT_COLS(5), .OUT_ROWS(1), .RELU(0)) dut_b (
        .clk(clk), .reset(reset), .i_start(start_b), .i_strip_done(done_b), .i_strip_data(data_b),
        .o_strip_addr(addr_b), .o_busy(busy_b), .o_frame_done(fdone_b), .out_if(ifb.master));

    assign ifb.out_ready = 1'b1;

    function automatic int fdat(int k, int n);
        return (k == 0) ? n : int'(lut[k][n % 256]);
    endfunction

    function automatic int ref_pix(int sum, bit relu);
        int v;
        v = (sum + 32) >>> 6;
        if (relu && v < 0) v = 0;
        return (v > 127) ? 127 : (v < -128) ? -128 : v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (beat %0d)", nm, got, exp, exp_idx);
        end
    endtask

    // Strip BRAMs: two-cycle address-to-data latency.
    always @(posedge clk) begin
        a1 <= addr; a2 <= a1; b1 <= addr_b; b2 <= b1;
    end
    always_comb begin
        data = '0;
        for (int k = 0; k < NS; k++) data[23*k +: 23] = 23'(fdat(k, int'(a2)));
        data_b = (int'(b2) < 5) ? 23'(tbl_b[int'(b2)]) : '0;
    end

    always @(posedge clk) begin
        #1 ifa.out_ready = rnd_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    always @(negedge clk) begin
        if (!reset && ifb.out_valid) begin
            qpix.push_back(int'(ifb.out_pixel));
            qcol.push_back(int'(ifb.out_col));
            qrow.push_back(int'(ifb.out_row));
        end
        if (!reset && fdone_b) fb_cnt++;
    end

    // Compare process: the expected beat stream is simply strip-major raster order of the BRAM contents.
    always @(negedge clk) begin
        int s, n, d;
        if (reset) begin
            exp_idx = 0; done_cnt = 0; addr_strip = 0; prev_addr = '0; prev_stall = 0; armed = 0;
        end else begin
            if (start && !busy) begin
                exp_idx = 0; done_cnt = 0; addr_strip = 0; armed = 1;
            end
            if (prev_addr != 0 && addr == 0) addr_strip++;
            prev_addr = addr;
            if (armed) begin
                d = addr_strip * N + int'(addr) - exp_idx;
                chk("addr_ahead", int'(d >= 0 && d <= DEPTH), 1);
            end
            if (prev_stall) chk("valid_hold", int'(ifa.out_valid), 1);
            if (ifa.out_valid) begin
                if (!armed || exp_idx >= TOTAL) chk("spurious_beat", 1, 0);
                else begin
                    s = exp_idx / N;
                    n = exp_idx % N;
                    chk("row", int'(ifa.out_row), s * R + n / C);
                    chk("col", int'(ifa.out_col), n % C);
                    chk("pixel", int'(ifa.out_pixel), ref_pix(fdat(s, n), 1));
                end
                if (ifa.out_ready) exp_idx++;
            end
            prev_stall = ifa.out_valid && !ifa.out_ready;
            if (fdone) begin
                chk("done_after_last", exp_idx, TOTAL);
                chk("done_once", done_cnt, 0);
                done_cnt++;
            end
        end
    end

    task automatic pulse(input bit b);
        @(posedge clk); #1;
        if (b) start_b = 1; else start = 1;
        @(posedge clk); #1;
        start = 0; start_b = 0;
    endtask

    task automatic wait_done(input int lim);
        int i = 0;
        while (done_cnt == 0 && i < lim) begin @(negedge clk); #1; i++; end
        chk("frame_done_seen", int'(done_cnt > 0), 1);
    endtask

    task automatic wait_beats(input int nb, input int lim);
        int i = 0;
        while (exp_idx < nb && i < lim) begin @(negedge clk); #1; i++; end
        chk("beats_reached", int'(exp_idx >= nb), 1);
    endtask

    initial begin
        for (int k = 0; k < NS; k++)
            for (int i = 0; i < 256; i++) begin
                int v;
                case (i % 4)
                    0: v = int'($urandom_range(0, 32'h7fffff)) - 32'sh400000;
                    1: v = int'($urandom_range(0, 20000)) - 10000;
                    2: v = int'($urandom_range(0, 400)) - 200;
                    default: v = int'($urandom_range(8000, 9000)) * ((i % 8 == 3) ? -1 : 1);
                endcase
                lut[k][i] = 23'(v);
            end
        chk("model_m1000", ref_pix(-1000, 0), -16);
        chk("model_8191", ref_pix(8191, 0), 127);
        chk("model_m8192", ref_pix(-8192, 0), -128);
        chk("model_relu", ref_pix(-1000, 1), 0);
        chk("model_6215", ref_pix(6215, 1), 97);
        chk("rq_relu_m1000", int'(requant(-23'sd1000, 4'd6, 1'b1)), 0);
        chk("rq_relu_m31", int'(requant(-23'sd31, 4'd6, 1'b1)), 0);
        chk("rq_relu_31", int'(requant(23'sd31, 4'd6, 1'b1)), 0);
        chk("rq_relu_8191", int'(requant(23'sd8191, 4'd6, 1'b1)), 127);
        chk("rq_relu_m8192", int'(requant(-23'sd8192, 4'd6, 1'b1)), 0);

        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst_addr", int'(addr), 0);
        chk("rst_valid", int'(ifa.out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(fdone), 0);
        chk("rst_pixel", int'(ifa.out_pixel), 0);
        chk("rst_row", int'(ifa.out_row), 0);
        chk("rst_col", int'(ifa.out_col), 0);

        done_b = 1;
        pulse(1);
        repeat (60) @(posedge clk);
        chk("b_beats", qpix.size(), 5);
        chk("b_done_cnt", fb_cnt, 1);
        for (int i = 0; i < 5 && i < qpix.size(); i++) begin
            chk("b_pixel", qpix[i], exp_b[i]);
            chk("b_col", qcol[i], i);
            chk("b_row", qrow[i], 0);
        end

        pulse(0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("wait_valid", int'(ifa.out_valid), 0);
        chk("wait_busy", int'(busy), 1);
        chk("wait_addr", int'(addr), 0);
        chk("wait_no_done", done_cnt, 0);
        @(posedge clk); #1 done[2] = 1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("other_strip_ignored", int'(ifa.out_valid), 0);
        @(posedge clk); #1 done[0] = 1;
        repeat (100) @(posedge clk);
        pulse(0);
        @(posedge clk); #1 done[1] = 1;
        wait_done(30000);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("f1_beats", exp_idx, TOTAL);
        chk("f1_done_cnt", done_cnt, 1);
        chk("f1_busy", int'(busy), 0);

        rnd_ready = 1;
        pulse(0);
        wait_done(45000);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("f2_beats", exp_idx, TOTAL);
        chk("f2_done_cnt", done_cnt, 1);

        pulse(0);
        wait_beats(1000, 5000);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1;
        chk("abort_valid", int'(ifa.out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_addr", int'(addr), 0);
        reset = 0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("abort_quiet_valid", int'(ifa.out_valid), 0);
        chk("abort_no_done", done_cnt, 0);
        pulse(0);
        wait_beats(300, 3000);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
